// File: rtl/frame_sequencer_if.sv
// Frame sequencer register/strobe bundle.
//   reg_4017     : $4017 contents (bit 7 mode, bit 6 IRQ inhibit)
//   reg_change   : toggles once per $4017 write, bus-clock domain
//   irq_ack      : one-clk pulse on a $4015 read
//   enable_240hz : quarter-frame strobe
//   enable_120hz : half-frame strobe
//   frame_irq    : level frame interrupt flag
// master = register/CPU side, slave = sequencer.
interface frame_sequencer_if;
  logic [7:0] reg_4017;
  logic       reg_change;
  logic       irq_ack;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;

  modport master (
    output reg_4017, reg_change, irq_ack,
    input  enable_240hz, enable_120hz, frame_irq
  );

  modport slave (
    input  reg_4017, reg_change, irq_ack,
    output enable_240hz, enable_120hz, frame_irq
  );
endinterface

// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides clk by STEP_PERIOD into sequencer steps and
// issues quarter-frame / half-frame strobes plus the frame IRQ.
//   clk   : CPU-rate clock
//   rst_n : asynchronous active-low reset
//   bus   : frame_sequencer_if.slave ($4017 config in, strobes/IRQ out)
module frame_sequencer #(
  parameter int STEP_PERIOD = 7457,
  parameter int DIV_WIDTH   = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  frame_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} step_t;

  logic [1:0]           sync;
  logic                 chg_q;
  logic                 reload;
  logic                 mode;
  logic                 inhibit;
  logic [DIV_WIDTH-1:0] div;
  logic                 terminal;
  step_t                step_q, step_d;
  logic                 s240_d, s120_d, irq_set;
  logic                 s240_q, s120_q, irq_q;

  // reg_4017[5:0] carries nothing the sequencer uses.
  logic unused_bits;
  assign unused_bits = ^bus.reg_4017[5:0];

  assign terminal = (div == DIV_WIDTH'(STEP_PERIOD - 1));

  // Two-flop synchronizer, then edge detect against the previous synced
  // value; reload lands exactly one clk, three edges after the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      chg_q  <= 1'b0;
      reload <= 1'b0;
    end else begin
      sync   <= {sync[0], bus.reg_change};
      chg_q  <= sync[1];
      reload <= sync[1] ^ chg_q;
    end
  end

  // $4017 is only sampled on reload; the bus may hold anything otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode    <= 1'b0;
      inhibit <= 1'b0;
    end else if (reload) begin
      mode    <= bus.reg_4017[7];
      inhibit <= bus.reg_4017[6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div <= '0;
    else if (reload || terminal) div <= '0;
    else                         div <= div + 1'b1;
  end

  // Step FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= S0;
    else        step_q <= step_d;
  end

  // Step FSM: next state. Reload wins over a coincident terminal.
  always_comb begin
    step_d = step_q;
    if (reload) begin
      step_d = S0;
    end else if (terminal) begin
      case (step_q)
        S0:      step_d = S1;
        S1:      step_d = S2;
        S2:      step_d = S3;
        S3:      step_d = mode ? S4 : S0;
        default: step_d = S0;
      endcase
    end
  end

  // Step FSM: outputs (pre-register strobe/IRQ-set decode).
  // A 5-step reload fires both strobes immediately; a terminal in the
  // reload cycle is dropped.
  always_comb begin
    s240_d  = 1'b0;
    s120_d  = 1'b0;
    irq_set = 1'b0;
    if (reload) begin
      s240_d = bus.reg_4017[7];
      s120_d = bus.reg_4017[7];
    end else if (terminal) begin
      case (step_q)
        S0: s240_d = 1'b1;
        S1: begin s240_d = 1'b1; s120_d = 1'b1; end
        S2: s240_d = 1'b1;
        S3: if (!mode) begin
              s240_d  = 1'b1;
              s120_d  = 1'b1;
              irq_set = 1'b1;
            end
        S4: begin s240_d = 1'b1; s120_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s240_q <= 1'b0;
      s120_q <= 1'b0;
    end else begin
      s240_q <= s240_d;
      s120_q <= s120_d;
    end
  end

  // Inhibit (new or latched) beats set; set beats ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            irq_q <= 1'b0;
    else if (reload && bus.reg_4017[6])    irq_q <= 1'b0;
    else if (inhibit)                      irq_q <= 1'b0;
    else if (irq_set)                      irq_q <= 1'b1;
    else if (bus.irq_ack)                  irq_q <= 1'b0;
  end

  assign bus.enable_240hz = s240_q;
  assign bus.enable_120hz = s120_q;
  assign bus.frame_irq    = irq_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  localparam int P = 10;

  logic clk, rst_n;
  frame_sequencer_if bus_if();

  frame_sequencer #(.STEP_PERIOD(P), .DIV_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] sb[$];

  // model state: edges since divider restarted, latched mode/inhibit, IRQ
  int k = 0;
  bit mode_e = 0, inh_e = 0, irq_e = 0;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d {240,120,irq} got %b want %b", tag, k, obs, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus_if.enable_240hz, bus_if.enable_120hz, bus_if.frame_irq};
  endfunction

  task automatic pop_chk(input string tag);
    logic [2:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_empty"}, outs(), 3'bxxx);
    end else begin
      e = sb.pop_front();
      chk(tag, outs(), e);
    end
  endtask

  // Strobe pattern seen after edge n of a frame that started with divider 0.
  task automatic pattern(input int n, input bit m, output bit s240, output bit s120,
                         output bit set);
    int s;
    s240 = 0; s120 = 0; set = 0;
    if (n > 0 && n % P == 0) begin
      s = (n / P - 1) % (m ? 5 : 4);
      if (m) begin
        s240 = (s != 3);
        s120 = (s == 1 || s == 4);
      end else begin
        s240 = 1;
        s120 = (s == 1 || s == 3);
        set  = (s == 3);
      end
    end
  endtask

  task automatic tick(input bit ack);
    bit s240, s120, set;
    k++;
    pattern(k, mode_e, s240, s120, set);
    if (inh_e)    irq_e = 0;
    else if (set) irq_e = 1;
    else if (ack) irq_e = 0;
    sb.push_back({s240, s120, irq_e});
    bus_if.irq_ack = ack;
    @(posedge clk); #1;
    bus_if.irq_ack = 1'b0;
    pop_chk(ack ? "ack" : "run");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  // Write $4017: toggle, three synchronizer edges, then the reload edge.
  task automatic write_4017(input logic [7:0] d);
    bus_if.reg_4017   = d;
    bus_if.reg_change = ~bus_if.reg_change;
    ticks(3);
    if (d[6]) irq_e = 0;
    sb.push_back({d[7], d[7], irq_e});
    @(posedge clk); #1;
    k = 0; mode_e = d[7]; inh_e = d[6];
    pop_chk("reload");
    // scribble on the bus without a toggle; must be ignored
    bus_if.reg_4017 = ~d;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.reg_4017 = 8'h00;
    bus_if.reg_change = 1'b0;
    bus_if.irq_ack = 1'b0;
    #3;
    sb.push_back(3'b000);
    pop_chk("reset");
    @(negedge clk) rst_n = 1'b1;

    // free-running 4-step: strobes at 10/20/30/40, IRQ at 40
    ticks(85);
    // ack clears next cycle
    tick(1);
    while (k < 119) tick(0);
    // ack coincident with step-3 terminal: set wins
    tick(1);
    tick(1);

    // 5-step mode: immediate pulse, 50-edge period, no IRQ
    write_4017(8'h80);
    ticks(110);

    // 4-step, let IRQ set, then inhibit it across three frames
    write_4017(8'h00);
    ticks(45);
    write_4017(8'h40);
    ticks(130);

    // reload coinciding with terminal, 4-step then 5-step
    write_4017(8'h00);
    while (k % P != 6) tick(0);
    write_4017(8'h00);
    ticks(25);
    while (k % P != 6) tick(0);
    write_4017(8'h80);
    ticks(25);

    // async reset mid-frame, right as step 1 strobe is out (step now 2)
    write_4017(8'h00);
    ticks(60);
    rst_n = 1'b0;
    bus_if.reg_change = 1'b0;
    #1;
    sb.push_back(3'b000);
    pop_chk("async_rst");
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(3'b000);
    pop_chk("in_rst");
    @(negedge clk) rst_n = 1'b1;
    k = 0; mode_e = 0; inh_e = 0; irq_e = 0;
    ticks(45);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
